// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes, FSM states and width helper for the calculator integer unit
package calc_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} stateT;

  // Smallest width able to count 0..value-1; never below one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/twoc_muldiv_unit_if.sv
// rtl/twoc_muldiv_unit_if.sv - start/result handshake bundle of the multiply/divide engine
interface twoc_muldiv_unit_if #(
  parameter int N = 8
);
  logic         startValid;
  logic         startReady;
  logic         opcode;
  logic [N-1:0] operandA;
  logic [N-1:0] operandB;
  logic         resultValid;
  logic         resultReady;
  logic [N-1:0] resultHi;
  logic [N-1:0] resultLo;
  logic         divByZero;
  logic         overflow;
  logic         busy;

  modport master (
    output startValid, opcode, operandA, operandB, resultReady,
    input  startReady, resultValid, resultHi, resultLo, divByZero, overflow, busy
  );

  modport slave (
    input  startValid, opcode, operandA, operandB, resultReady,
    output startReady, resultValid, resultHi, resultLo, divByZero, overflow, busy
  );
endinterface

// File: rtl/twoc_muldiv_unit_cond_negate.sv
// rtl/twoc_muldiv_unit_cond_negate.sv - conditional two's-complement negation
module cond_negate #(
  parameter int W = 8
) (
  input  logic         neg,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);
  assign out = neg ? (~in + W'(1)) : in;
endmodule

// File: rtl/twoc_muldiv_unit.sv
// rtl/twoc_muldiv_unit.sv - sequential signed shift-add multiply / restoring divide engine
module twoc_muldiv_unit
  import calc_pkg::*;
#(
  parameter int N = 8
) (
  input logic               clk,
  input logic               rst_n,
  twoc_muldiv_unit_if.slave bus
);
  localparam int CW = clog2(N);

  stateT          state, stateNext;
  logic           opReg, signA, signB, divZero;
  logic [N-1:0]   magA, magB, absA, absB;
  logic [2*N-1:0] acc, accNext, prodFixed;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   hiReg, loReg, quoFixed, remFixed;
  logic           dzReg, ovReg;
  logic           accept, lastIter, zeroDiv;
  logic [N:0]     mulSum, trial;

  cond_negate #(.W(N))   uAbsA (.neg(bus.operandA[N-1]), .in(bus.operandA), .out(absA));
  cond_negate #(.W(N))   uAbsB (.neg(bus.operandB[N-1]), .in(bus.operandB), .out(absB));
  cond_negate #(.W(2*N)) uProd (.neg(signA ^ signB), .in(acc), .out(prodFixed));
  cond_negate #(.W(N))   uQuo  (.neg(signA ^ signB), .in(acc[N-1:0]), .out(quoFixed));
  cond_negate #(.W(N))   uRem  (.neg(signA), .in(acc[2*N-1:N]), .out(remFixed));

  assign accept   = (state == IDLE) && bus.startValid;
  assign zeroDiv  = (bus.opcode == OP_DIV) && (bus.operandB == '0);
  assign lastIter = (cnt == CW'(N - 1));

  // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, quotient}.
  always_comb begin
    mulSum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, magA} : '0);
    trial  = {1'b0, acc[2*N-2:N-1]} - {1'b0, magB};
    if (opReg == OP_MUL)
      accNext = {mulSum, acc[N-1:1]};
    else if (!trial[N])
      accNext = {trial[N-1:0], acc[N-2:0], 1'b1};
    else
      accNext = {acc[2*N-2:0], 1'b0};
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = zeroDiv ? FIX : ITER;
      ITER:    if (lastIter) stateNext = FIX;
      FIX:     stateNext = DONE;
      DONE:    if (bus.resultReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opReg   <= OP_MUL;
      signA   <= 1'b0;
      signB   <= 1'b0;
      divZero <= 1'b0;
      magA    <= '0;
      magB    <= '0;
      acc     <= '0;
      cnt     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      dzReg   <= 1'b0;
      ovReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          opReg   <= bus.opcode;
          signA   <= bus.operandA[N-1];
          signB   <= bus.operandB[N-1];
          magA    <= absA;
          magB    <= absB;
          cnt     <= '0;
          divZero <= zeroDiv;
          // A zero divisor parks |A| in the remainder half so the remainder fix restores A.
          if (bus.opcode == OP_MUL) acc <= {{N{1'b0}}, absB};
          else if (zeroDiv)         acc <= {absA, {N{1'b0}}};
          else                      acc <= {{N{1'b0}}, absA};
        end
        ITER: begin
          acc <= accNext;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          if (opReg == OP_MUL) begin
            hiReg <= prodFixed[2*N-1:N];
            loReg <= prodFixed[N-1:0];
            dzReg <= 1'b0;
            ovReg <= 1'b0;
          end else if (divZero) begin
            hiReg <= remFixed;
            loReg <= '1;
            dzReg <= 1'b1;
            ovReg <= 1'b0;
          end else begin
            hiReg <= remFixed;
            loReg <= quoFixed;
            dzReg <= 1'b0;
            // Only -2^(N-1) / -1 yields a positive quotient magnitude of 2^(N-1).
            ovReg <= acc[N-1] & ~(signA ^ signB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.startReady  = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.resultValid = (state == DONE);
  assign bus.resultHi    = hiReg;
  assign bus.resultLo    = loReg;
  assign bus.divByZero   = dzReg;
  assign bus.overflow    = ovReg;
endmodule

// File: tb/tb_twoc_muldiv_unit.sv
// tb/tb_twoc_muldiv_unit.sv - directed and randomized checks of twoc_muldiv_unit against an arithmetic model
module tb_twoc_muldiv_unit;
  import calc_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  twoc_muldiv_unit_if #(.N(N)) bus ();
  twoc_muldiv_unit #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Signed arithmetic straight from the operation rules, truncating division.
  function automatic void model(input logic op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] hi, output logic [7:0] lo,
                                output logic dz, output logic ov);
    int sa, sb, q, r;
    logic [15:0] p;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    ov = 1'b0;
    if (op == OP_MUL) begin
      p  = 16'(sa * sb);
      hi = p[15:8];
      lo = p[7:0];
    end else if (sb == 0) begin
      hi = a;
      lo = 8'hFF;
      dz = 1'b1;
    end else if (sa == -128 && sb == -1) begin
      hi = 8'h00;
      lo = 8'h80;
      ov = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = 8'(r);
      lo = 8'(q);
    end
  endfunction

  task automatic runOp(input string tag, input logic op, input logic [7:0] a, input logic [7:0] b,
                       input int hold, input bit earlyReady);
    logic [7:0] eHi, eLo;
    logic       eDz, eOv;
    int         lat, eLat;
    model(op, a, b, eHi, eLo, eDz, eOv);
    eLat = (op == OP_DIV && b == 8'h00) ? 2 : N + 2;
    @(negedge clk);
    check({tag, " startReady idle"}, bus.startReady, 1);
    bus.startValid = 1'b1;
    bus.opcode     = op;
    bus.operandA   = a;
    bus.operandB   = b;
    @(posedge clk);
    #1;
    bus.startValid = 1'b0;
    bus.opcode     = 1'($urandom);
    bus.operandA   = 8'($urandom);
    bus.operandB   = 8'($urandom);
    if (earlyReady) bus.resultReady = 1'b1;
    @(negedge clk);
    lat = 1;
    while (bus.resultValid !== 1'b1 && lat < 40) begin
      if (lat == 3) bus.resultReady = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, eLat);
    for (int i = 0; i < hold; i++) begin
      check({tag, " held valid"}, bus.resultValid, 1);
      check({tag, " held startReady"}, bus.startReady, 0);
      check({tag, " held hi"}, bus.resultHi, eHi);
      check({tag, " held lo"}, bus.resultLo, eLo);
      @(negedge clk);
    end
    check({tag, " hi"}, bus.resultHi, eHi);
    check({tag, " lo"}, bus.resultLo, eLo);
    check({tag, " divByZero"}, bus.divByZero, eDz);
    check({tag, " overflow"}, bus.overflow, eOv);
    check({tag, " busy"}, bus.busy, 1);
    bus.resultReady = 1'b1;
    @(negedge clk);
    bus.resultReady = 1'b0;
    check({tag, " startReady after"}, bus.startReady, 1);
    check({tag, " valid dropped"}, bus.resultValid, 0);
    check({tag, " hi kept"}, bus.resultHi, eHi);
    check({tag, " lo kept"}, bus.resultLo, eLo);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic       op;
    logic [7:0] a, b;
    bus.startValid  = 1'b0;
    bus.opcode      = OP_MUL;
    bus.operandA    = '0;
    bus.operandB    = '0;
    bus.resultReady = 1'b0;
    repeat (2) @(negedge clk);
    check("reset startReady", bus.startReady, 1);
    check("reset busy", bus.busy, 0);
    check("reset valid", bus.resultValid, 0);
    check("reset hi", bus.resultHi, 0);
    check("reset lo", bus.resultLo, 0);
    check("reset flags", {bus.divByZero, bus.overflow}, 0);
    rst_n = 1'b1;

    runOp("mul fb*07", OP_MUL, 8'hFB, 8'h07, 0, 1'b0);
    runOp("mul 80*80", OP_MUL, 8'h80, 8'h80, 0, 1'b0);
    runOp("div f9/02", OP_DIV, 8'hF9, 8'h02, 0, 1'b0);
    runOp("div 25/00", OP_DIV, 8'h25, 8'h00, 0, 1'b0);
    runOp("div 80/ff", OP_DIV, 8'h80, 8'hFF, 0, 1'b0);
    runOp("backpressure", OP_MUL, 8'h9C, 8'h35, 5, 1'b1);
    runOp("div 7f/80", OP_DIV, 8'h7F, 8'h80, 2, 1'b0);

    // Abort during the fourth iteration cycle.
    @(negedge clk);
    bus.startValid = 1'b1;
    bus.opcode     = OP_MUL;
    bus.operandA   = 8'h5A;
    bus.operandB   = 8'hC3;
    @(posedge clk);
    #1;
    bus.startValid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort startReady", bus.startReady, 1);
    check("abort busy", bus.busy, 0);
    check("abort valid", bus.resultValid, 0);
    check("abort hi", bus.resultHi, 0);
    check("abort lo", bus.resultLo, 0);
    check("abort flags", {bus.divByZero, bus.overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (N + 6) begin
      @(negedge clk);
      if (bus.resultValid === 1'b1) seen++;
    end
    check("abort no valid", seen, 0);

    for (int i = 0; i < 150; i++) begin
      op = 1'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      case ($urandom_range(0, 9))
        0: b = 8'h00;
        1: begin a = 8'h80; b = 8'hFF; end
        2: a = 8'h80;
        default: ;
      endcase
      runOp("random", op, a, b, $urandom_range(0, 2), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
